// File: rtl/ram_port_arbiter.sv
// ---------------------------------------------------------------------------
// ram_port_arbiter
//
// Round-robin arbiter and sequencer in front of a single-port synchronous
// RAM macro.  Two requesters (A and B) issue independent read/write
// transactions over a req/ack handshake.  Each transaction is serialized
// onto the RAM pins and walks through IDLE -> ISSUE -> (WAIT) -> RESP before
// the next request is considered.
//
// Parameters:
//   ADDR_W  RAM address width
//   DATA_W  RAM data width
//   RD_LAT  edges from the RAM sampling the address to q valid (1..3)
//
// Ports:
//   clock_50mhz          system clock, rising edge
//   reset                synchronous active-high reset
//   a_req/a_we/a_addr/a_wdata   port A request (held until a_ack)
//   a_ack/a_rdata        port A completion pulse and read data
//   b_*                  same as port A, for port B
//   ram_addr/ram_data/ram_wren  to the RAM macro
//   ram_q                from the RAM macro
//   busy                 high whenever the sequencer is not idle
// ---------------------------------------------------------------------------
module ram_port_arbiter #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8,
   parameter int RD_LAT = 1
) (
   input  logic              clock_50mhz,
   input  logic              reset,
   input  logic              a_req,
   input  logic              a_we,
   input  logic [ADDR_W-1:0] a_addr,
   input  logic [DATA_W-1:0] a_wdata,
   output logic              a_ack,
   output logic [DATA_W-1:0] a_rdata,
   input  logic              b_req,
   input  logic              b_we,
   input  logic [ADDR_W-1:0] b_addr,
   input  logic [DATA_W-1:0] b_wdata,
   output logic              b_ack,
   output logic [DATA_W-1:0] b_rdata,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_data,
   output logic              ram_wren,
   input  logic [DATA_W-1:0] ram_q,
   output logic              busy
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

   // Index of the final WAIT cycle; the RAM output is captured on its edge.
   localparam logic [1:0] LAST_WAIT = 2'(RD_LAT - 1);

   state_t              state_q;
   logic                last_grant_q;   // 0 = A, 1 = B
   logic                owner_q;        // 0 = A, 1 = B
   logic                we_q;
   logic [1:0]          wait_cnt_q;
   logic [ADDR_W-1:0]   ram_addr_q;
   logic [DATA_W-1:0]   ram_data_q;
   logic                ram_wren_q;
   logic                a_ack_q;
   logic                b_ack_q;
   logic [DATA_W-1:0]   a_rdata_q;
   logic [DATA_W-1:0]   b_rdata_q;
   logic                busy_q;

   logic                grant_vld_d;
   logic                grant_b_d;
   logic                sel_we_d;
   logic [ADDR_W-1:0]   sel_addr_d;
   logic [DATA_W-1:0]   sel_wdata_d;

   // Arbitration: a lone requester wins outright; on contention the port
   // that did not win last time is chosen, which makes grants alternate.
   always_comb begin
      grant_vld_d = a_req | b_req;
      grant_b_d   = 1'b0;
      if (a_req && b_req) begin
         grant_b_d = ~last_grant_q;
      end else begin
         grant_b_d = b_req;
      end
      sel_we_d    = grant_b_d ? b_we    : a_we;
      sel_addr_d  = grant_b_d ? b_addr  : a_addr;
      sel_wdata_d = grant_b_d ? b_wdata : a_wdata;
   end

   always_ff @(posedge clock_50mhz) begin
      if (reset) begin
         state_q      <= IDLE;
         last_grant_q <= 1'b1;
         owner_q      <= 1'b0;
         we_q         <= 1'b0;
         wait_cnt_q   <= 2'd0;
         ram_addr_q   <= '0;
         ram_data_q   <= '0;
         ram_wren_q   <= 1'b0;
         a_ack_q      <= 1'b0;
         b_ack_q      <= 1'b0;
         a_rdata_q    <= '0;
         b_rdata_q    <= '0;
         busy_q       <= 1'b0;
      end else begin
         // Acks are single-cycle pulses; only the WAIT/ISSUE exits raise them.
         a_ack_q <= 1'b0;
         b_ack_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (grant_vld_d) begin
                  owner_q      <= grant_b_d;
                  last_grant_q <= grant_b_d;
                  we_q         <= sel_we_d;
                  // RAM pins are loaded here so they are valid during ISSUE.
                  ram_addr_q   <= sel_addr_d;
                  ram_data_q   <= sel_wdata_d;
                  ram_wren_q   <= sel_we_d;
                  busy_q       <= 1'b1;
                  state_q      <= ISSUE;
               end
            end
            ISSUE: begin
               ram_wren_q <= 1'b0;
               wait_cnt_q <= 2'd0;
               if (we_q) begin
                  a_ack_q <= ~owner_q;
                  b_ack_q <= owner_q;
                  state_q <= RESP;
               end else begin
                  state_q <= WAIT;
               end
            end
            WAIT: begin
               if (wait_cnt_q == LAST_WAIT) begin
                  if (owner_q) begin
                     b_rdata_q <= ram_q;
                  end else begin
                     a_rdata_q <= ram_q;
                  end
                  a_ack_q <= ~owner_q;
                  b_ack_q <= owner_q;
                  state_q <= RESP;
               end else begin
                  wait_cnt_q <= wait_cnt_q + 2'd1;
               end
            end
            RESP: begin
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign a_ack    = a_ack_q;
   assign b_ack    = b_ack_q;
   assign a_rdata  = a_rdata_q;
   assign b_rdata  = b_rdata_q;
   assign ram_addr = ram_addr_q;
   assign ram_data = ram_data_q;
   assign ram_wren = ram_wren_q;
   assign busy     = busy_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
module tb_ram_port_arbiter;

   logic       clk = 1'b0;
   logic       reset;
   int         cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- DUT with RD_LAT = 1 ----------------
   logic       a_req, a_we, b_req, b_we;
   logic [7:0] a_addr, a_wdata, b_addr, b_wdata;
   logic       a_ack, b_ack, ram_wren, busy;
   logic [7:0] a_rdata, b_rdata, ram_addr, ram_data, ram_q;

   ram_port_arbiter #(.ADDR_W(8), .DATA_W(8), .RD_LAT(1)) dut (
      .clock_50mhz(clk), .reset(reset),
      .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
      .a_ack(a_ack), .a_rdata(a_rdata),
      .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
      .b_ack(b_ack), .b_rdata(b_rdata),
      .ram_addr(ram_addr), .ram_data(ram_data), .ram_wren(ram_wren),
      .ram_q(ram_q), .busy(busy)
   );

   // ---------------- DUT with RD_LAT = 3 ----------------
   logic       a3_req, a3_we, b3_req, b3_we;
   logic [7:0] a3_addr, a3_wdata, b3_addr, b3_wdata;
   logic       a3_ack, b3_ack, ram3_wren, busy3;
   logic [7:0] a3_rdata, b3_rdata, ram3_addr, ram3_data, ram3_q;

   ram_port_arbiter #(.ADDR_W(8), .DATA_W(8), .RD_LAT(3)) dut3 (
      .clock_50mhz(clk), .reset(reset),
      .a_req(a3_req), .a_we(a3_we), .a_addr(a3_addr), .a_wdata(a3_wdata),
      .a_ack(a3_ack), .a_rdata(a3_rdata),
      .b_req(b3_req), .b_we(b3_we), .b_addr(b3_addr), .b_wdata(b3_wdata),
      .b_ack(b3_ack), .b_rdata(b3_rdata),
      .ram_addr(ram3_addr), .ram_data(ram3_data), .ram_wren(ram3_wren),
      .ram_q(ram3_q), .busy(busy3)
   );

   // ---------------- RAM models (never-written cells read addr^0x5A) ----
   bit [7:0] mem1 [256];
   bit       wr1  [256];
   always @(posedge clk) begin
      if (ram_wren) begin
         mem1[ram_addr] <= ram_data;
         wr1[ram_addr]  <= 1'b1;
      end
      ram_q <= wr1[ram_addr] ? mem1[ram_addr] : (ram_addr ^ 8'h5A);
   end

   bit [7:0]   mem3 [256];
   bit         wr3  [256];
   logic [7:0] p3_0, p3_1;
   always @(posedge clk) begin
      if (ram3_wren) begin
         mem3[ram3_addr] <= ram3_data;
         wr3[ram3_addr]  <= 1'b1;
      end
      p3_0   <= wr3[ram3_addr] ? mem3[ram3_addr] : (ram3_addr ^ 8'h5A);
      p3_1   <= p3_0;
      ram3_q <= p3_1;
   end

   // ---------------- scoreboard ----------------
   typedef struct {
      int         inst;
      bit         port;
      bit         rd;
      logic [7:0] data;
      int         cyc;
   } exp_t;
   exp_t sbq[$];

   int vecs = 0;
   int errs = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      vecs++;
      if (act !== req) begin
         errs++;
         $display("FAIL %s: actual 0x%0h required 0x%0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic push(input int inst, input bit port, input bit rd,
                       input logic [7:0] data, input int c);
      exp_t e;
      e.inst = inst; e.port = port; e.rd = rd; e.data = data; e.cyc = c;
      sbq.push_back(e);
   endtask

   task automatic mon_check(input int inst, input bit port, input bit both,
                            input logic [7:0] rd);
      exp_t e;
      if (sbq.size() == 0) begin
         vecs++;
         errs++;
         $display("FAIL unexpected_ack: inst %0d port %0d at cycle %0d, required none", inst, port, cyc);
      end else begin
         e = sbq.pop_front();
         chk("ack_inst", inst, e.inst);
         chk("ack_port", 32'(port), 32'(e.port));
         chk("ack_cycle", cyc, e.cyc);
         if (e.rd) chk("rdata", 32'(rd), 32'(e.data));
         chk("ack_overlap", 32'(both), 32'd0);
      end
   endtask

   // Monitor: samples on the falling edge, away from the active edge.
   always @(negedge clk) begin
      if (a_ack || b_ack)
         mon_check(0, b_ack, a_ack && b_ack, b_ack ? b_rdata : a_rdata);
      if (a3_ack || b3_ack)
         mon_check(1, b3_ack, a3_ack && b3_ack, b3_ack ? b3_rdata : a3_rdata);
   end

   // Write-pulse log for the RD_LAT=1 instance.
   int         wr_cnt = 0;
   logic [7:0] wr_addr, wr_data;
   always @(negedge clk) begin
      if (ram_wren) begin
         wr_cnt++;
         wr_addr = ram_addr;
         wr_data = ram_data;
      end
   end

   // Idle-cycle counter over a window set by the stimulus.
   int bw_lo = 1000000, bw_hi = 0, busy0 = 0;
   always @(negedge clk) begin
      if (cyc >= bw_lo && cyc <= bw_hi && !busy) busy0++;
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int inst, input bit port, input bit we,
                        input logic [7:0] addr, input logic [7:0] wdata);
      bit done = 1'b0;
      if (inst == 0) begin
         if (port) begin b_req = 1; b_we = we; b_addr = addr; b_wdata = wdata; end
         else      begin a_req = 1; a_we = we; a_addr = addr; a_wdata = wdata; end
      end else begin
         a3_req = 1; a3_we = we; a3_addr = addr; a3_wdata = wdata;
      end
      for (int i = 0; i < 40 && !done; i++) begin
         tick();
         if (inst == 0 && !port && a_ack) begin a_req = 0; done = 1; end
         if (inst == 0 &&  port && b_ack) begin b_req = 0; done = 1; end
         if (inst != 0 && a3_ack)         begin a3_req = 0; done = 1; end
      end
      if (!done) begin
         vecs++;
         errs++;
         $display("FAIL ack_timeout: inst %0d port %0d no ack within 40 cycles, required ack", inst, port);
         if (inst == 0 && !port) a_req = 0;
         if (inst == 0 &&  port) b_req = 0;
         if (inst != 0)          a3_req = 0;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, c0;
      reset = 1;
      a_req = 1; a_we = 0; a_addr = 8'h00; a_wdata = 8'h00;
      b_req = 1; b_we = 0; b_addr = 8'h01; b_wdata = 8'h00;
      a3_req = 0; a3_we = 0; a3_addr = 0; a3_wdata = 0;
      b3_req = 0; b3_we = 0; b3_addr = 0; b3_wdata = 0;

      // Reset held two edges with both requests high.
      tick();
      tick();
      @(negedge clk);
      chk("rst_a_ack", 32'(a_ack), 0);
      chk("rst_b_ack", 32'(b_ack), 0);
      chk("rst_a_rdata", 32'(a_rdata), 0);
      chk("rst_b_rdata", 32'(b_rdata), 0);
      chk("rst_ram_addr", 32'(ram_addr), 0);
      chk("rst_ram_data", 32'(ram_data), 0);
      chk("rst_ram_wren", 32'(ram_wren), 0);
      chk("rst_busy", 32'(busy), 0);
      tick();
      reset = 0;

      // First grant after reset goes to A (reads of untouched cells).
      n = cyc;
      push(0, 0, 1, 8'h5A, n + 3);
      push(0, 1, 1, 8'h5B, n + 7);
      fork
         drive(0, 0, 0, 8'h00, 8'h00);
         drive(0, 1, 0, 8'h01, 8'h00);
      join
      tick();

      // A writes 0x10 <= 0xA5.
      n = cyc; c0 = wr_cnt;
      push(0, 0, 0, 8'h00, n + 2);
      drive(0, 0, 1, 8'h10, 8'hA5);
      chk("wr_pulses", wr_cnt - c0, 1);
      chk("wr_addr", 32'(wr_addr), 32'h10);
      chk("wr_data", 32'(wr_data), 32'hA5);
      tick();

      // A reads 0x10 back.
      n = cyc; c0 = wr_cnt;
      push(0, 0, 1, 8'hA5, n + 3);
      drive(0, 0, 0, 8'h10, 8'h00);
      chk("rd_no_wren", wr_cnt - c0, 0);
      tick();

      // B pre-writes 0x20 <= 0x3C.
      n = cyc;
      push(0, 1, 0, 8'h00, n + 2);
      drive(0, 1, 1, 8'h20, 8'h3C);
      tick();

      // Contention: both read in the same cycle, A first.
      n = cyc;
      push(0, 0, 1, 8'hA5, n + 3);
      push(0, 1, 1, 8'h3C, n + 7);
      fork
         drive(0, 0, 0, 8'h10, 8'h00);
         drive(0, 1, 0, 8'h20, 8'h00);
      join
      tick();

      // Fairness: both keep requesting writes for 8 transactions.
      n = cyc;
      for (int k = 0; k < 8; k++) push(0, k[0], 0, 8'h00, n + 2 + 3 * k);
      bw_lo = n + 1; bw_hi = n + 23; busy0 = 0;
      fork
         begin
            for (int k = 0; k < 4; k++) drive(0, 0, 1, 8'h40 + 8'(k), 8'h90 + 8'(k));
         end
         begin
            for (int k = 0; k < 4; k++) drive(0, 1, 1, 8'h50 + 8'(k), 8'hB0 + 8'(k));
         end
      join
      tick();
      chk("idle_gaps", busy0, 7);

      // Reset during WAIT of a B read: no ack, everything back to idle.
      n = cyc;
      b_req = 1; b_we = 0; b_addr = 8'h20;
      tick();
      tick();
      reset = 1; b_req = 0;
      tick();
      @(negedge clk);
      chk("midrst_b_ack", 32'(b_ack), 0);
      chk("midrst_b_rdata", 32'(b_rdata), 0);
      chk("midrst_busy", 32'(busy), 0);
      chk("midrst_wren", 32'(ram_wren), 0);
      tick();
      reset = 0;
      n = cyc;
      push(0, 1, 1, 8'h3C, n + 3);
      drive(0, 1, 0, 8'h20, 8'h00);
      tick();

      // RD_LAT = 3 instance: write ack at 2, read ack at 5.
      n = cyc;
      push(1, 0, 0, 8'h00, n + 2);
      drive(1, 0, 1, 8'h33, 8'hC7);
      tick();
      n = cyc;
      push(1, 0, 1, 8'hC7, n + 5);
      drive(1, 0, 0, 8'h33, 8'h00);
      tick();

      repeat (4) tick();
      chk("sb_drained", sbq.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
